// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matrix-multiply dimensions and result-reader state encoding
//
// Purpose: one place for the result matrix geometry (A x C elements of
// OUT_BITS each, stored flat as M3_L words) and the reader FSM states.
// It is shared by the multiplier and by matmul_result_reader.
package matmul_pkg;

  localparam int A        = 16;
  localparam int C        = 24;
  localparam int OUT_BITS = 32;
  localparam int M3_L     = A * C;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with first-word-fall-through head
//
// Purpose: holds returned read data plus its tag until downstream accepts it.
// The head entry is visible combinationally on head_data_o whenever the FIFO
// is not empty.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears storage too)
//   push_i        write push_data_i at the tail
//   push_data_i   entry to write
//   pop_i         remove the head entry (ignored when empty)
//   head_data_o   current head entry
//   count_o       number of entries held
//   empty_o       no entries held
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/matmul_result_reader.sv
// rtl/matmul_result_reader.sv - streams the flat result RAM out as tagged row/col beats
//
// Purpose: on start, reads every element of the A x C result RAM in
// row-major order and presents each as a valid/ready beat carrying its row,
// column and a last flag on the final element. At most two elements are ever
// outstanding (buffered plus in flight), so downstream may stall indefinitely.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request a full pass (honoured only when idle)
//   busy, done               pass in progress / one-cycle completion pulse
//   m3_rd_en, m3_rd_addr     RAM read strobe and flat address (row*C + col)
//   m3_rd_data               RAM data, valid the cycle after m3_rd_en
//   out_valid, out_ready     stream handshake
//   out_data, out_row,
//   out_col, out_last        beat payload
module matmul_result_reader
  import matmul_pkg::state_t, matmul_pkg::IDLE, matmul_pkg::READ,
         matmul_pkg::DRAIN, matmul_pkg::DONE;
#(
  parameter int A        = matmul_pkg::A,
  parameter int C        = matmul_pkg::C,
  parameter int OUT_BITS = matmul_pkg::OUT_BITS,
  localparam int M3_L    = A * C,
  localparam int AW      = (M3_L > 1) ? $clog2(M3_L) : 1,
  localparam int RW      = (A > 1) ? $clog2(A) : 1,
  localparam int CW      = (C > 1) ? $clog2(C) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                m3_rd_en,
  output logic [AW-1:0]       m3_rd_addr,
  input  logic [OUT_BITS-1:0] m3_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                out_last
);

  localparam int FIFO_DEPTH = 2;
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int EW         = RW + CW + 1 + OUT_BITS;

  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic [AW-1:0]   addr_q;

  // Tag of the read issued last cycle; it travels with the data the RAM returns now.
  logic            inflight_q;
  logic [RW-1:0]   tag_row_q;
  logic [CW-1:0]   tag_col_q;
  logic            tag_last_q;

  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_head;
  logic              head_last;
  logic              pop;
  logic              rd_en;
  logic              at_last_elem;
  logic [2:0]        credit_used;

  assign at_last_elem = (row_q == RW'(A - 1)) && (col_q == CW'(C - 1));
  assign pop          = !fifo_empty && out_ready;

  // Slots committed after this edge: what is buffered plus what is arriving,
  // minus the beat leaving now. Keeping this below 2 guarantees the 2-entry
  // FIFO can always absorb the data of every issued read.
  assign credit_used  = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  assign rd_en        = (state_q == READ) && (credit_used < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        tag_row_q  <= row_q;
        tag_col_q  <= col_q;
        tag_last_q <= at_last_elem;
      end
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
          end
        end
        READ: begin
          if (rd_en) begin
            // Counters hold on the final element so the address never leaves the RAM.
            if (at_last_elem) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
              if (col_q == CW'(C - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({tag_row_q, tag_col_q, tag_last_q, m3_rd_data}),
    .pop_i       (pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign head_last  = fifo_head[OUT_BITS];

  assign busy       = busy_q;
  assign done       = done_q;
  assign m3_rd_en   = rd_en;
  assign m3_rd_addr = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_head[OUT_BITS-1:0];
  assign out_col    = fifo_head[OUT_BITS+1 +: CW];
  assign out_row    = fifo_head[OUT_BITS+1+CW +: RW];
  // The head slot keeps stale contents after the final pop; last is only meaningful with valid.
  assign out_last   = head_last && !fifo_empty;

endmodule

// File: doc/matmul_result_reader.md
MATMUL_RESULT_READER -- requirements
Module: matmul_result_reader

Interface
REQ-001 Parameter A, default 16, result matrix rows.
REQ-002 Parameter C, default 24, result matrix columns.
REQ-003 Parameter OUT_BITS, default 32, result element width.
REQ-004 Derived constant M3_L = A*C, flat result RAM depth; address width AW = $clog2(M3_L).
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle request to stream the whole result RAM.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse after the final output handshake.
REQ-010 m3_rd_en  output  1  result RAM read strobe.
REQ-011 m3_rd_addr  output  AW  result RAM read address, flat row-major (row*C + col).
REQ-012 m3_rd_data  input  OUT_BITS  RAM read data, valid exactly 1 cycle after m3_rd_en.
REQ-013 out_valid  output  1  stream beat available.
REQ-014 out_ready  input  1  downstream accepts beat.
REQ-015 out_data  output  OUT_BITS  element value.
REQ-016 out_row  output  $clog2(A)  row index of out_data.
REQ-017 out_col  output  $clog2(C)  column index of out_data.
REQ-018 out_last  output  1  high with element (A-1, C-1) only.

Function
REQ-019 FSM states: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer not empty), DONE (one cycle, done=1), then IDLE.
REQ-020 IDLE + start=1: next cycle READ, busy=1, row=col=0; start in any other state is ignored.
REQ-021 Read order: col inner, row outer; after (r, C-1) comes (r+1, 0); after (A-1, C-1) go to DRAIN.
REQ-022 m3_rd_en asserts in READ only when buffer_count + inflight - pop_this_cycle < 2 (credit rule); address advances only on an issued read.
REQ-023 Returned data is pushed, with its row/col tag, into a 2-entry FIFO at the end of the cycle after the read; the FIFO head drives out_data/out_row/out_col/out_last; out_valid = FIFO not empty.
REQ-024 Handshake: beat transfers on out_valid & out_ready; while out_valid & ~out_ready, all out_* remain stable.
REQ-025 Latency: start sampled at edge k -> m3_rd_en=1, addr 0 in cycle k+1 -> out_valid=1 in cycle k+3.
REQ-026 With out_ready held 1, exactly M3_L beats are emitted on consecutive cycles with no bubbles.
REQ-027 out_ready=0 for any duration: reads stop after at most 2 outstanding elements (buffered plus in flight); no data is lost or duplicated.
REQ-028 DRAIN -> DONE on the handshake of the out_last beat; done=1 in DONE; busy drops in the same cycle done rises.
REQ-029 Read addresses never exceed M3_L-1; the row/col counters never wrap mid-stream.
REQ-030 Push and pop in the same cycle with FIFO full is legal; the count is unchanged.

Reset
REQ-031 rst=1: state=IDLE, FIFO empty, inflight=0, counters=0; busy, done, m3_rd_en, out_valid, out_last = 0; out_data, out_row, out_col, m3_rd_addr = 0.
REQ-032 rst mid-stream aborts immediately: no done pulse; read data returning in the cycle after reset is discarded.
REQ-033 rst has priority over start in the same cycle.

Structure
REQ-034 A, C, OUT_BITS, M3_L and the state enum live in shared package matmul_pkg, also used by the multiplier.
REQ-035 A single sub-module sync_fifo (parameters DEPTH=2, WIDTH) holds {row, col, last, data}; the FSM and address counters live in the top.

Verification
REQ-036 A=2, C=3, RAM[i]=i+100, out_ready=1, start at cycle 0 -> out_valid cycles 3..8, data 100..105, (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), out_last at cycle 8, done at cycle 9.
REQ-037 Same setup, out_ready toggling 1,0,1,0,... -> the same 6 beats in order; at most 2 reads ahead of the last accepted beat; out_* stable while stalled.
REQ-038 out_ready=0 for 20 cycles after start -> exactly 2 m3_rd_en pulses, then 6 correct beats after release.
REQ-039 start re-pulsed while busy -> ignored; exactly 6 beats and one done pulse.
REQ-040 rst at cycle 5 mid-stream -> all outputs 0 next cycle; a new start then streams 100..105 correctly.
REQ-041 Default parameters, random out_ready -> 384 beats, address = row*24+col for every beat, single out_last.
